chunk_serial_adder: RTL and testbench
=====================================

Name: chunk_serial_adder

Overview:
Multi-cycle, parametrised successor to the combinational 4-bit ripple adder. Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, through one shared CHUNK-bit ripple slice. Uses valid/ready handshakes on input and output. Trades latency for area in wide datapaths and reports unsigned carry-out and signed overflow.

Parameters:
WIDTH, 16, operand/sum width; must be a multiple of CHUNK.
CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH.
NCHUNK (localparam), WIDTH/CHUNK, number of RUN cycles per operation.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  operand A, sampled on accept
b  input  WIDTH  operand B, sampled on accept
cin  input  1  carry-in, sampled on accept
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  (a + b + cin) mod 2^WIDTH
cout  output  1  unsigned carry out of the MSB
ovf  output  1  signed two's-complement overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high. While rst is high: state=IDLE, sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1, internal carry=0, chunk index=0.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On an edge with in_valid=1, latch a, b and cin into operand registers; carry <= cin; idx <= 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN: on each edge, sum[idx*CHUNK +: CHUNK] <= a_chunk + b_chunk + carry; carry <= slice carry-out; idx <= idx+1.
  - On the edge where idx == NCHUNK-1: cout <= slice carry-out; ovf <= (a_msb == b_msb) && (new sum_msb != a_msb); go to DONE.
- DONE: out_valid=1.
  - sum, cout and ovf are stable and held while out_ready=0.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
- Latency: accept at edge k; out_valid is high after edge k+NCHUNK. Minimum issue interval is NCHUNK+2 cycles. CHUNK==WIDTH gives a single RUN cycle.
- in_valid is ignored outside IDLE; a, b and cin may change freely after accept.
- sum bits not yet written in RUN hold their previous values. sum is only meaningful while out_valid=1.
- Reset asserted mid-RUN or in DONE: the operation is discarded and no out_valid is produced.
- idx width is clog2(NCHUNK), minimum 1. idx never exceeds NCHUNK-1.

Optional Feature:
Macro CHUNK_ADDSUB_EN.
- Defined: adds input port op_sub (1 bit), sampled on accept with the operands.
  - op_sub=1: b_eff = ~b and the initial carry is forced to 1, so the result is a - b and cin is ignored. cout=1 means no borrow. ovf uses b_eff_msb.
  - op_sub=0: behaviour is identical to the macro being absent.
- Absent: the port does not exist and the block is add-only.

Decomposition:
- Package chunk_adder_pkg: state typedef (IDLE/RUN/DONE encoding) and a clog2 helper function.
- One sub-module, chunk_ripple_slice: combinational CHUNK-bit ripple adder (ci, x, y -> s, co) built from full-adder equations. It is instantiated once and time-shared across chunks.

Test Plan:
All scenarios use WIDTH=16, CHUNK=4.
1. a=0x000A, b=0x000A, cin=0, out_ready=1 -> sum=0x0014, cout=0, ovf=0; out_valid rises exactly 4 cycles after the accept edge and lasts 1 cycle.
2. a=0xFFFF, b=0xFFFF, cin=0 -> sum=0xFFFE, cout=1, ovf=0. Then a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0 (carry crosses every chunk).
3. a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a -> out_valid stays 1, sum/cout/ovf stay unchanged, in_ready=0, and no second accept occurs. Raise out_ready -> IDLE the next cycle with in_ready=1.
5. Assert rst asynchronously (between edges) during the 2nd RUN cycle -> outputs go to reset values immediately and in_ready=1. out_valid never rises for that operation; the next operation computes correctly.
6. With CHUNK_ADDSUB_EN defined:
   - op_sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0.
   - op_sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
   - op_sub=1, a=0x0005, b=0x0007, cin=1 -> same result as cin=0 (cin ignored).

Source files
------------

// File: rtl/chunk_adder_pkg.sv
// Shared types and helpers for the chunk-serial adder.
package chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2, never smaller than 1 so index registers always exist.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < n; p = p << 1) begin
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/chunk_ripple_slice.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder equations.
module chunk_ripple_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic             ci,
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic c;

  always_comb begin
    c = ci;
    s = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder: WIDTH-bit a+b+cin computed CHUNK bits per clock through one shared slice.
// Optional subtract mode (op_sub port) is enabled by defining CHUNK_ADDSUB_EN.
module chunk_serial_adder
  import chunk_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CHUNK_ADDSUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = clog2_min1(NCHUNK);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic              sub_c, last_c, slice_co;
  logic [CHUNK-1:0]  slice_s;

`ifdef CHUNK_ADDSUB_EN
  assign sub_c = op_sub;
`else
  assign sub_c = 1'b0;
`endif

  assign last_c = (idx_q == IDXW'(NCHUNK - 1));

  chunk_ripple_slice #(.CHUNK(CHUNK)) u_slice (
    .ci (carry_q),
    .x  (a_q[idx_q*CHUNK +: CHUNK]),
    .y  (b_q[idx_q*CHUNK +: CHUNK]),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_c)    state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Operand capture and one chunk of ripple per RUN cycle; b is stored already inverted for subtract.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == ST_IDLE && in_valid) begin
      a_d     = a;
      b_d     = b ^ {WIDTH{sub_c}};
      carry_d = sub_c | cin;
      idx_d   = '0;
    end else if (state_q == ST_RUN) begin
      sum_d[idx_q*CHUNK +: CHUNK] = slice_s;
      carry_d = slice_co;
      idx_d   = last_c ? '0 : IDXW'(idx_q + 1'b1);
      if (last_c) begin
        cout_d = slice_co;
        ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[CHUNK-1] != a_q[WIDTH-1]);
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed bench for chunk_serial_adder (WIDTH=16, CHUNK=4) with an arithmetic reference model.
module tb_chunk_serial_adder;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CHUNK  = 4;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, cin, op_sub;
  logic [WIDTH-1:0] a, b, sum;
  logic             out_valid, out_ready, cout, ovf, busy;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] m_sum;
  logic             m_cout, m_ovf, m_set;

  chunk_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CHUNK_ADDSUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as seen at accept.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                               input logic mcin, input logic msub);
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   full;
    logic             o;
    be   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, be} + {{WIDTH{1'b0}}, (msub ? 1'b1 : mcin)};
    o    = (ma[WIDTH-1] == be[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
    return {o, full};
  endfunction

  // Compare process: results checked against the model whenever out_valid is high.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_vs_busy", WIDTH'(in_ready), WIDTH'(!busy));
      if (out_valid) begin
        check("result_expected", WIDTH'(m_set), WIDTH'(1'b1));
        check("sum_model", sum, m_sum);
        check("cout_model", WIDTH'(cout), WIDTH'(m_cout));
        check("ovf_model", WIDTH'(ovf), WIDTH'(m_ovf));
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_timeout", WIDTH'(in_ready), WIDTH'(1'b1));
  endtask

  task automatic accept(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vcin, input logic vsub);
    logic [WIDTH+1:0] r;
    @(negedge clk);
    wait_ready();
    r      = model(va, vb, vcin, vsub);
    m_sum  = r[WIDTH-1:0];
    m_cout = r[WIDTH];
    m_ovf  = r[WIDTH+1];
    m_set  = 1'b1;
    a = va; b = vb; cin = vcin; op_sub = vsub; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = ~va; b = ~vb; cin = ~vcin;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vcin,
                        input logic vsub, input int hold, input logic [WIDTH-1:0] esum,
                        input logic ecout, input logic eovf);
    out_ready = (hold == 0);
    accept(va, vb, vcin, vsub);
    for (int j = 0; j <= int'(NCHUNK); j++) begin
      if (j > 0) @(negedge clk);
      check("out_valid_latency", WIDTH'(out_valid), WIDTH'(j == int'(NCHUNK)));
    end
    check("sum_literal", sum, esum);
    check("cout_literal", WIDTH'(cout), WIDTH'(ecout));
    check("ovf_literal", WIDTH'(ovf), WIDTH'(eovf));
    for (int h = 0; h < hold; h++) begin
      in_valid = ~in_valid;
      a = a + 16'h1111;
      @(negedge clk);
      check("hold_valid", WIDTH'(out_valid), WIDTH'(1'b1));
      check("hold_in_ready", WIDTH'(in_ready), WIDTH'(1'b0));
      check("hold_sum", sum, esum);
      check("hold_cout", WIDTH'(cout), WIDTH'(ecout));
      check("hold_ovf", WIDTH'(ovf), WIDTH'(eovf));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    m_set = 1'b0;
    check("valid_drop", WIDTH'(out_valid), WIDTH'(1'b0));
    check("idle_in_ready", WIDTH'(in_ready), WIDTH'(1'b1));
  endtask

  typedef struct {
    logic [WIDTH-1:0] a, b;
    logic             cin, sub;
    int               hold;
    logic [WIDTH-1:0] s;
    logic             co, ov;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
    m_set = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    #12;
    check("rst_sum", sum, '0);
    check("rst_out_valid", WIDTH'(out_valid), '0);
    check("rst_busy", WIDTH'(busy), '0);
    check("rst_in_ready", WIDTH'(in_ready), WIDTH'(1'b1));
    check("rst_cout_ovf", WIDTH'({cout, ovf}), '0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{16'h000A, 16'h000A, 1'b0, 1'b0, 0, 16'h0014, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 0, 16'hFFFE, 1'b1, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{16'h1234, 16'h4321, 1'b1, 1'b0, 5, 16'h5556, 1'b0, 1'b0});
`ifdef CHUNK_ADDSUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 0, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 0, 16'h7FFF, 1'b1, 1'b1});
    vecs.push_back('{16'h0005, 16'h0007, 1'b1, 1'b1, 0, 16'hFFFE, 1'b0, 1'b0});
`endif
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].hold,
             vecs[i].s, vecs[i].co, vecs[i].ov);
    end

    // Asynchronous reset during the second RUN cycle discards the operation.
    out_ready = 1'b1;
    accept(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    m_set = 1'b0;
    check("midrun_rst_valid", WIDTH'(out_valid), '0);
    check("midrun_rst_busy", WIDTH'(busy), '0);
    check("midrun_rst_in_ready", WIDTH'(in_ready), WIDTH'(1'b1));
    check("midrun_rst_sum", sum, '0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < int'(NCHUNK) + 3; k++) begin
      @(negedge clk);
      check("discarded_no_valid", WIDTH'(out_valid), '0);
    end
    run_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 0, 16'hBCDE, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
